// File: rtl/mux_2to1_pkg.sv
// ============================================================================
// Module  : mux_2to1_pkg
// Purpose : Shared datapath constants for the MIPS core muxes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_2to1_pkg;

  // Native datapath word width of the core.
  localparam int DATA_WIDTH = 32;

  // Select-line encodings used by callers of the 2:1 datapath mux.
  localparam logic SEL_D1 = 1'b0;
  localparam logic SEL_D2 = 1'b1;

endpackage : mux_2to1_pkg

`default_nettype wire

// File: rtl/mux_2to1.sv
// ============================================================================
// Module  : mux_2to1
// Purpose : WIDTH-bit 2:1 datapath multiplexer (ALU operand B, reg-dest,
//           write-back and PC-source selects) with an optional registered
//           copy of the output for use at a pipeline boundary.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             Sel,
  output logic [WIDTH-1:0] Dout,
  output logic [WIDTH-1:0] Dout_q
);

  // Next-state value of the pipeline register is simply the live mux output.
  logic [WIDTH-1:0] dout_d;

  // Zero-latency selection; an unknown Sel X-merges the two inputs in sim.
  assign Dout   = (Sel == SEL_D2) ? D2 : D1;
  assign dout_d = Dout;

  // Pipeline-boundary copy of Dout; trimmed by synthesis when left unconnected.
  always_ff @(posedge clk) begin
    if (rst) begin
      Dout_q <= '0;
    end else begin
      Dout_q <= dout_d;
    end
  end

endmodule : mux_2to1

`default_nettype wire

// File: tb/tb_mux_2to1.sv
// ============================================================================
// Module  : tb_mux_2to1
// Purpose : Self-checking bench for mux_2to1 (directed cases plus random).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_2to1;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic             Sel;
  logic [WIDTH-1:0] Dout;
  logic [WIDTH-1:0] Dout_q;

  int checks = 0;
  int errors = 0;

  // Expected Dout_q values, one per issued clock cycle.
  logic [WIDTH-1:0] exp_q[$];

  mux_2to1 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .D1     (D1),
    .D2     (D2),
    .Sel    (Sel),
    .Dout   (Dout),
    .Dout_q (Dout_q)
  );

  // Clock held low for the first 20 ns so the early checks see no edge.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  // Reference: pick the input indexed by the select value.
  function automatic logic [WIDTH-1:0] ref_pick(input logic s,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ins [2];
    ins[0] = a;
    ins[1] = b;
    return ins[s ? 1 : 0];
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, check Dout at once and
  // queue the value Dout_q must show after the next rising edge.
  task automatic cycle(input string name, input logic r, input logic s,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    rst = r;
    Sel = s;
    D1  = a;
    D2  = b;
    #1;
    check({name, "_dout"}, Dout, ref_pick(s, a, b));
    exp_q.push_back(r ? '0 : ref_pick(s, a, b));
  endtask

  // Monitor: Dout_q is presented every rising edge; compare against queue.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout_q", Dout_q, e);
      end
    end
  end

  // Stimulus.
  initial begin
    logic             rs;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    rst = 1'b0;
    Sel = 1'b0;
    D1  = '0;
    D2  = 32'd1;
    #5;
    check("t1_sel0", Dout, 32'd0);
    Sel = 1'b1;
    #1;
    check("t2_sel1", Dout, 32'd1);

    D1  = 32'hDEADBEEF;
    D2  = 32'h12345678;
    Sel = 1'b0;
    #1;
    check("t3_a", Dout, 32'hDEADBEEF);
    Sel = 1'b1;
    #1;
    check("t3_b", Dout, 32'h12345678);
    Sel = 1'b0;
    #1;
    check("t3_c", Dout, 32'hDEADBEEF);

    // Reset held for two edges with D2 all-ones selected.
    cycle("t4_rst0", 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF);
    cycle("t4_rst1", 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF);
    // Release reset.
    cycle("t5_a5", 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
    cycle("t5_d1", 1'b0, 1'b0, 32'h00000003, 32'hA5A5A5A5);
    cycle("t5_a5b", 1'b0, 1'b1, 32'h00000003, 32'hA5A5A5A5);
    // Reset mid-stream with Dout_q holding A5A5A5A5.
    cycle("t6_rst", 1'b1, 1'b1, 32'h00000003, 32'hA5A5A5A5);
    cycle("t6_rel", 1'b0, 1'b0, 32'h00000003, 32'hA5A5A5A5);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 200; i++) begin
      rs = ($urandom_range(0, 15) == 0);
      ra = $urandom;
      rb = $urandom;
      cycle("rand", rs, 1'($urandom_range(0, 1)), ra, rb);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_2to1

`default_nettype wire
